// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   8-bit, 16-function registered arithmetic/logic unit.
//   A op B is evaluated combinationally from ALU_Sel, and the result and the
//   carry/status bit are registered. Outputs are valid one clock after the
//   operands and the select are applied. A new operation is accepted every
//   cycle, with no handshake.
//
// Ports
//   clk       in   1  clock, rising-edge active
//   rst       in   1  synchronous reset, active-high, has priority over all ops
//   A         in   8  operand A, unsigned
//   B         in   8  operand B, unsigned
//   ALU_Sel   in   4  operation select (all 16 codes are defined)
//   ALU_Out   out  8  registered result
//   CarryOut  out  1  registered carry / borrow / status bit
// -----------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  alu_op_e     op_sel;
  logic [8:0]  sum_ext;
  logic [8:0]  diff_ext;
  logic [15:0] prod;
  logic [7:0]  quot;
  logic        div_by_zero;
  logic [7:0]  res_nxt;
  logic        carry_nxt;

  assign op_sel = alu_op_e'(ALU_Sel);

  // The 9th bit of the zero-extended subtraction is the borrow. It is set
  // exactly when A < B.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign prod     = A * B;

  // The divisor is forced to 1 when B is zero, so the divider never sees a
  // zero operand. The result for that case is replaced below anyway.
  assign div_by_zero = (B == 8'h00);
  assign quot        = A / (div_by_zero ? 8'h01 : B);

  always_comb begin
    res_nxt   = 8'h00;
    carry_nxt = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        res_nxt   = sum_ext[7:0];
        carry_nxt = sum_ext[8];
      end
      OP_SUB: begin
        res_nxt   = diff_ext[7:0];
        carry_nxt = diff_ext[8];
      end
      OP_MUL: begin
        res_nxt   = prod[7:0];
        carry_nxt = |prod[15:8];
      end
      OP_DIV: begin
        res_nxt   = div_by_zero ? 8'hFF : quot;
        carry_nxt = div_by_zero;
      end
      OP_SHL: begin
        res_nxt   = {A[6:0], 1'b0};
        carry_nxt = A[7];
      end
      OP_SHR: begin
        res_nxt   = {1'b0, A[7:1]};
        carry_nxt = A[0];
      end
      OP_ROL:  res_nxt = {A[6:0], A[7]};
      OP_ROR:  res_nxt = {A[0], A[7:1]};
      OP_AND:  res_nxt = A & B;
      OP_OR:   res_nxt = A | B;
      OP_XOR:  res_nxt = A ^ B;
      OP_NOR:  res_nxt = ~(A | B);
      OP_NAND: res_nxt = ~(A & B);
      OP_XNOR: res_nxt = ~(A ^ B);
      OP_GT:   res_nxt = (A > B)  ? 8'h01 : 8'h00;
      OP_EQ:   res_nxt = (A == B) ? 8'h01 : 8'h00;
      default: begin
        res_nxt   = 8'h00;
        carry_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Out  <= 8'h00;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= res_nxt;
      CarryOut <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu. It runs a directed sequence of known-answer
//   vectors and then a block of random vectors. The random vectors are checked
//   against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int n_vec;
  int n_err;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic. The return value is
  // {carry, result}.
  function automatic logic [8:0] ref_model(input int sel, input int a, input int b);
    int r;
    int c;
    r = 0;
    c = 0;
    case (sel)
      0:  begin r = (a + b) % 256;       c = ((a + b) > 255) ? 1 : 0; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;         end
      2:  begin r = (a * b) % 256;       c = ((a * b) > 255) ? 1 : 0; end
      3:  begin
            if (b == 0) begin r = 255; c = 1; end
            else        begin r = a / b; c = 0; end
          end
      4:  begin r = (a * 2) % 256;       c = (a >= 128) ? 1 : 0; end
      5:  begin r = a / 2;               c = a % 2;              end
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: begin r = 0; c = 0; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp_r, input logic exp_c);
    n_vec++;
    assert ({ALU_Out, CarryOut} === {exp_r, exp_c})
    else begin
      n_err++;
      $error("FAIL %s: observed %02h/%0b expected %02h/%0b", tag, ALU_Out, CarryOut, exp_r, exp_c);
    end
  endtask

  // Drive the operands just after a rising edge, then check 1 ns after the
  // following edge.
  task automatic apply(input string tag, input logic [3:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_r, input logic exp_c);
    ALU_Sel = sel;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check(tag, exp_r, exp_c);
  endtask

  initial begin
    logic [8:0] exp;
    int         ra;
    int         rb;
    int         rs;

    n_vec = 0;
    n_err = 0;

    // Hold reset for 2 cycles with arbitrary operands applied.
    rst = 1'b1;
    A = 8'hFF;
    B = 8'h01;
    ALU_Sel = 4'd0;
    @(posedge clk);
    #1;
    check("reset_c1", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_c2", 8'h00, 1'b0);
    rst = 1'b0;

    // Sweep A=08, B=09 through select codes 1..15, then 0.
    apply("sub",  4'd1,  8'h08, 8'h09, 8'hFF, 1'b1);
    apply("mul",  4'd2,  8'h08, 8'h09, 8'h48, 1'b0);
    apply("div",  4'd3,  8'h08, 8'h09, 8'h00, 1'b0);
    apply("shl",  4'd4,  8'h08, 8'h09, 8'h10, 1'b0);
    apply("shr",  4'd5,  8'h08, 8'h09, 8'h04, 1'b0);
    apply("rol",  4'd6,  8'h08, 8'h09, 8'h10, 1'b0);
    apply("ror",  4'd7,  8'h08, 8'h09, 8'h04, 1'b0);
    apply("and",  4'd8,  8'h08, 8'h09, 8'h08, 1'b0);
    apply("or",   4'd9,  8'h08, 8'h09, 8'h09, 1'b0);
    apply("xor",  4'd10, 8'h08, 8'h09, 8'h01, 1'b0);
    apply("nor",  4'd11, 8'h08, 8'h09, 8'hF6, 1'b0);
    apply("nand", 4'd12, 8'h08, 8'h09, 8'hF7, 1'b0);
    apply("xnor", 4'd13, 8'h08, 8'h09, 8'hFE, 1'b0);
    apply("gt",   4'd14, 8'h08, 8'h09, 8'h00, 1'b0);
    apply("eq",   4'd15, 8'h08, 8'h09, 8'h00, 1'b0);
    apply("add",  4'd0,  8'h08, 8'h09, 8'h11, 1'b0);

    // Carry and borrow edge cases.
    apply("add_carry",  4'd0, 8'hFF, 8'h01, 8'h00, 1'b1);
    apply("sub_noborr", 4'd1, 8'h03, 8'h01, 8'h02, 1'b0);
    apply("mul_ovf",    4'd2, 8'h10, 8'h10, 8'h00, 1'b1);
    apply("shl_carry",  4'd4, 8'h80, 8'h00, 8'h00, 1'b1);
    apply("shr_carry",  4'd5, 8'h81, 8'h00, 8'h40, 1'b1);
    apply("rol_wrap",   4'd6, 8'h81, 8'h00, 8'h03, 1'b0);
    apply("ror_wrap",   4'd7, 8'h81, 8'h00, 8'hC0, 1'b0);

    // Division by zero and a normal divide.
    apply("div_zero", 4'd3, 8'h03, 8'h00, 8'hFF, 1'b1);
    apply("div_ff10", 4'd3, 8'hFF, 8'h10, 8'h0F, 1'b0);

    // Comparisons.
    apply("gt_true",  4'd14, 8'h03, 8'h01, 8'h01, 1'b0);
    apply("eq_false", 4'd15, 8'h03, 8'h01, 8'h00, 1'b0);
    apply("eq_true",  4'd15, 8'h5A, 8'h5A, 8'h01, 1'b0);

    // The output holds while the inputs stay stable.
    @(posedge clk);
    #1;
    check("hold", 8'h01, 1'b0);

    // Change the select mid-cycle. The output must not move until the next
    // rising edge.
    apply("lat_pre", 4'd0, 8'h20, 8'h05, 8'h25, 1'b0);
    #3;
    ALU_Sel = 4'd1;
    #1;
    check("lat_mid", 8'h25, 1'b0);
    @(posedge clk);
    #1;
    check("lat_post", 8'h1B, 1'b0);

    // Reset takes priority over a live operation. After release, the next
    // edge shows the operation result.
    A = 8'hFF;
    B = 8'h01;
    ALU_Sel = 4'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_prio", 8'h00, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", 8'h00, 1'b1);

    // Random vectors checked against the reference model. Roughly one in
    // eight uses B = 0 so the divide-by-zero path is exercised.
    for (int i = 0; i < 400; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 15));
      exp = ref_model(rs, ra, rb);
      apply("random", rs[3:0], ra[7:0], rb[7:0], exp[7:0], exp[8]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
